// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues single-cycle word requests, and holds one
// fetched instruction for decode. One-edge latency; Stall holds a FULL entry and masks IMemReq.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] InstrAddrOut,
  output logic        InstrValid
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        vld_q, vld_d;
  logic        accept;

  // Request stays up while EMPTY even under Stall; only a held FULL entry blocks it.
  assign IMemReq  = !Reset && !(vld_q && Stall);
  assign IMemAddr = pc_q;
  assign accept   = IMemReq && IMemReady && !BranchTaken;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    vld_d   = vld_q;
    if (BranchTaken) begin
      pc_d    = BranchAddr & WORD_MASK;
      instr_d = 32'h0;
      vld_d   = 1'b0;
    end else if (accept) begin
      pc_d    = pc_q + 32'd4;
      instr_d = IMemData;
      iaddr_d = pc_q;
      vld_d   = 1'b1;
    end else if (!Stall) begin
      instr_d = 32'h0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_PC & WORD_MASK;
      instr_q <= 32'h0;
      iaddr_q <= 32'h0;
      vld_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      vld_q   <= vld_d;
    end
  end

  assign Instruction  = instr_q;
  assign InstrAddrOut = iaddr_q;
  assign InstrValid   = vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a cycle model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchAddr = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] InstrAddrOut;
  logic        InstrValid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what decode should see and where the PC should point.
  logic [31:0] m_pc, m_instr, m_addr;
  logic        m_vld;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchAddr(BranchAddr), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Instruction(Instruction),
    .InstrAddrOut(InstrAddrOut), .InstrValid(InstrValid)
  );

  always #5 Clock = ~Clock;

  // Memory returns a tagged copy of the requested address.
  always_comb IMemData = IMemAddr ^ KEY;

  task automatic model_reset();
    m_pc = RPC; m_instr = 32'h0; m_addr = 32'h0; m_vld = 1'b0;
  endtask

  // Apply inputs at the negedge, advance the model by the fetch rules, wait one full cycle.
  task automatic cycle(input logic st, input logic br, input logic [31:0] ba, input logic rdy);
    logic req;
    Stall = st; BranchTaken = br; BranchAddr = ba; IMemReady = rdy;
    req = !(m_vld && st);
    if (br) begin
      m_pc = {ba[31:2], 2'b00}; m_instr = 32'h0; m_vld = 1'b0;
    end else if (req && rdy) begin
      m_instr = m_pc ^ KEY; m_addr = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_instr = 32'h0; m_vld = 1'b0;
    end
    @(posedge Clock);
    @(negedge Clock);
    Stall = 1'b0; BranchTaken = 1'b0; IMemReady = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge Clock);
    n_cmp++;
    if ({IMemReq, IMemAddr, Instruction, InstrAddrOut, InstrValid} !== {1'b0, RPC, 32'h0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold: req=%b addr=%h instr=%h iaddr=%h vld=%b, need 0 %h 0 0 0",
               IMemReq, IMemAddr, Instruction, InstrAddrOut, InstrValid, RPC);
    end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({IMemReq, IMemAddr} !== {1'b1, RPC}) begin
      n_err++;
      $display("FAIL reset_release_req: req=%b addr=%h, need 1 %h", IMemReq, IMemAddr, RPC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = RPC + 32'(4 * i);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if ({Instruction, InstrAddrOut, InstrValid} !== {a ^ KEY, a, 1'b1}) begin
        n_err++;
        $display("FAIL stream_%0d: instr=%h iaddr=%h vld=%b, need %h %h 1",
                 i, Instruction, InstrAddrOut, InstrValid, a ^ KEY, a);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      Stall = 1'b1; IMemReady = 1'b1;
      #1;
      n_cmp++;
      if ({IMemReq, IMemAddr} !== {1'b0, 32'h0000_010C}) begin
        n_err++;
        $display("FAIL stall_req_%0d: req=%b addr=%h, need 0 0000010c", i, IMemReq, IMemAddr);
      end
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if ({Instruction, InstrAddrOut, InstrValid} !== {32'h0000_0108 ^ KEY, 32'h0000_0108, 1'b1}) begin
        n_err++;
        $display("FAIL stall_hold_%0d: instr=%h iaddr=%h vld=%b, need entry 00000108",
                 i, Instruction, InstrAddrOut, InstrValid);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({InstrAddrOut, InstrValid} !== {32'h0000_010C, 1'b1}) begin
      n_err++;
      $display("FAIL stall_release: iaddr=%h vld=%b, need 0000010c 1", InstrAddrOut, InstrValid);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if ({Instruction, InstrValid, IMemReq, IMemAddr} !== {32'h0, 1'b0, 1'b1, 32'h0000_0110}) begin
        n_err++;
        $display("FAIL memwait_%0d: instr=%h vld=%b req=%b addr=%h, need 0 0 1 00000110",
                 i, Instruction, InstrValid, IMemReq, IMemAddr);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({Instruction, InstrAddrOut, InstrValid} !== {32'h0000_0110 ^ KEY, 32'h0000_0110, 1'b1}) begin
      n_err++;
      $display("FAIL memwait_deliver: instr=%h iaddr=%h vld=%b, need entry 00000110",
               Instruction, InstrAddrOut, InstrValid);
    end
  endtask

  task automatic test_branch();
    cycle(1'b0, 1'b1, 32'h0000_2003, 1'b1);
    n_cmp++;
    if ({Instruction, InstrValid, InstrAddrOut, IMemAddr} !== {32'h0, 1'b0, 32'h0000_0110, 32'h0000_2000}) begin
      n_err++;
      $display("FAIL branch_bubble: instr=%h vld=%b iaddr=%h addr=%h, need 0 0 00000110 00002000",
               Instruction, InstrValid, InstrAddrOut, IMemAddr);
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a;
      a = 32'h0000_2000 + 32'(4 * i);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if ({Instruction, InstrAddrOut, InstrValid} !== {a ^ KEY, a, 1'b1}) begin
        n_err++;
        $display("FAIL branch_target_%0d: instr=%h iaddr=%h vld=%b, need addr %h",
                 i, Instruction, InstrAddrOut, InstrValid, a);
      end
    end
  endtask

  task automatic test_branch_stall();
    cycle(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    n_cmp++;
    if ({Instruction, InstrValid, IMemAddr} !== {32'h0, 1'b0, 32'h0000_3000}) begin
      n_err++;
      $display("FAIL branch_stall: instr=%h vld=%b addr=%h, need 0 0 00003000",
               Instruction, InstrValid, IMemAddr);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({InstrAddrOut, InstrValid, IMemAddr} !== {32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL wrap: iaddr=%h vld=%b addr=%h, need fffffffc 1 00000000",
               InstrAddrOut, InstrValid, IMemAddr);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    Stall = 1'b1; IMemReady = 1'b0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({IMemReq, IMemAddr, Instruction, InstrAddrOut, InstrValid} !== {1'b0, RPC, 32'h0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: req=%b addr=%h instr=%h iaddr=%h vld=%b, need reset values",
               IMemReq, IMemAddr, Instruction, InstrAddrOut, InstrValid);
    end
    IMemReady = 1'b1; Stall = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if ({IMemReq, InstrValid, IMemAddr} !== {1'b0, 1'b0, RPC}) begin
      n_err++;
      $display("FAIL reset_mid_hold: req=%b vld=%b addr=%h, need 0 0 %h", IMemReq, InstrValid, IMemAddr, RPC);
    end
    Reset = 1'b0; IMemReady = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic st, br, rdy;
      logic [31:0] ba;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ba  = $urandom;
      Stall = st; BranchTaken = br; BranchAddr = ba; IMemReady = rdy;
      #1;
      n_cmp++;
      if ({IMemReq, IMemAddr} !== {!(m_vld && st), m_pc}) begin
        n_err++;
        $display("FAIL rand_req_%0d: req=%b addr=%h, need %b %h", i, IMemReq, IMemAddr, !(m_vld && st), m_pc);
      end
      cycle(st, br, ba, rdy);
      n_cmp++;
      if ({Instruction, InstrAddrOut, InstrValid} !== {m_instr, m_addr, m_vld}) begin
        n_err++;
        $display("FAIL rand_out_%0d: instr=%h iaddr=%h vld=%b, need %h %h %b",
                 i, Instruction, InstrAddrOut, InstrValid, m_instr, m_addr, m_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_mem_wait();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
